// File: rtl/des3_cbc_ctrl_pkg.sv
// Shared definitions for the 3DES CBC/ECB block sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package des3_pkg;

    // Cipher block width in bits.
    localparam int DES3_BLK_W = 64;

    // Default number of WAIT cycles before an unanswered core start is abandoned.
    localparam int DES3_DEFAULT_TIMEOUT = 1024;

    typedef logic [DES3_BLK_W-1:0] blk_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/des3_cbc_ctrl_if.sv
// Block streams around the 3DES sequencer: plaintext in, ciphertext out, core start/done.
// Latency: none (wiring only).
// Backpressure: in_ready / out_ready carry the valid-ready stalls; the core side has none.
interface des3_cbc_ctrl_if;
    import des3_pkg::*;

    logic in_valid;
    logic in_ready;
    blk_t in_data;
    logic in_last;

    logic out_valid;
    logic out_ready;
    blk_t out_data;
    logic out_last;

    logic core_select;
    blk_t core_data;
    blk_t core_out;
    logic core_done;

    // Controller side.
    modport master (
        input  in_valid, in_data, in_last,
        output in_ready,
        output out_valid, out_data, out_last,
        input  out_ready,
        output core_select, core_data,
        input  core_out, core_done
    );

    // Host buffer, sink and encrypt core side.
    modport slave (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  core_select, core_data,
        output core_out, core_done
    );

endinterface

// File: rtl/des3_cbc_ctrl.sv
// Streams blocks one at a time through a start/done 3DES core with CBC or ECB chaining.
// Latency: core latency + 3 cycles per block with out_ready high; one block in flight.
// Backpressure: in_ready low outside IDLE; out_valid held until out_ready. Optional macro DES3_CBC_TIMEOUT_EN.
module des3_cbc_ctrl
    import des3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DES3_DEFAULT_TIMEOUT,
    parameter int CNT_W          = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              cbc_en,
    input  blk_t              cfg_iv,
    input  logic              cfg_load_iv,
    des3_cbc_ctrl_if.master   bus,
    output logic [CNT_W-1:0]  blk_cnt,
    output logic              busy,
    output logic              err
);

    state_t state;
    blk_t   chain_reg;
    logic   last_q;
    logic   mode_q;

    logic   accept;
    blk_t   chain_src;

`ifdef DES3_CBC_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt;
`else
    assign err = 1'b0;
`endif

    // A load coinciding with the handshake must already chain this block.
    assign accept    = (state == IDLE) && bus.in_ready && bus.in_valid;
    assign chain_src = cfg_load_iv ? cfg_iv : chain_reg;

    // Sequencer: all outputs are registered and change with the state.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            chain_reg       <= '0;
            last_q          <= 1'b0;
            mode_q          <= 1'b0;
            bus.in_ready    <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            bus.out_last    <= 1'b0;
            bus.core_select <= 1'b0;
            bus.core_data   <= '0;
            blk_cnt         <= '0;
            busy            <= 1'b0;
`ifdef DES3_CBC_TIMEOUT_EN
            err             <= 1'b0;
            wait_cnt        <= '0;
`endif
        end else begin
            bus.core_select <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_load_iv) begin
                        chain_reg <= cfg_iv;
`ifdef DES3_CBC_TIMEOUT_EN
                        err       <= 1'b0;
`endif
                    end
                    if (accept) begin
                        bus.core_data   <= cbc_en ? (bus.in_data ^ chain_src) : bus.in_data;
                        last_q          <= bus.in_last;
                        mode_q          <= cbc_en;
                        bus.core_select <= 1'b1;
                        bus.in_ready    <= 1'b0;
                        busy            <= 1'b1;
                        state           <= ISSUE;
                    end else begin
                        // Also raises in_ready on the first cycle out of reset.
                        bus.in_ready <= 1'b1;
                    end
                end

                ISSUE, WAIT: begin
                    // An early done (already in ISSUE) is taken exactly like one in WAIT.
                    if (bus.core_done) begin
                        bus.out_data  <= bus.core_out;
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= last_q;
                        if (mode_q) begin
                            chain_reg <= bus.core_out;
                        end
                        state <= OUT;
                    end else if (state == ISSUE) begin
                        state <= WAIT;
`ifdef DES3_CBC_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
`ifdef DES3_CBC_TIMEOUT_EN
                    else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Core never answered: drop the block and restart the message.
                        err          <= 1'b1;
                        chain_reg    <= cfg_iv;
                        blk_cnt      <= '0;
                        busy         <= 1'b0;
                        bus.in_ready <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        if (last_q) begin
                            blk_cnt   <= '0;
                            chain_reg <= cfg_iv;
                        end else begin
                            blk_cnt <= blk_cnt + 1'b1;
                        end
                        busy         <= 1'b0;
                        bus.in_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
